// File: rtl/adc_sample_sink.sv
// adc_sample_sink
//   AXI4-Lite write-only responder for an ADC capture master. Each single-beat
//   write has its byte strobes applied (disabled bytes become 8'h00) and is
//   queued in a first-word-fall-through FIFO. The FIFO drains on an
//   AXI4-Stream-style valid/ready port. While the FIFO is full, the write
//   response is withheld, so no sample is dropped.
//
//   Optional build macro ADC_SINK_ADDR_CHECK_EN: writes whose address falls
//   outside [C_BASE_ADDR, C_BASE_ADDR + C_WINDOW_BYTES) are answered with
//   SLVERR. They are not stored or counted, and they do not wait on a full
//   FIFO. When the macro is undefined, every address is accepted with OKAY.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN : clock (rising edge) and async active-low reset
//   S_AXI_AW* / S_AXI_W*       : write address / write data channels
//   S_AXI_B*                   : write response channel (one outstanding)
//   M_AXIS_TDATA/TVALID/TREADY : head-of-FIFO sample stream
//   FIFO_LEVEL                 : FIFO occupancy, 0..2**FIFO_AW
//   SAMPLE_CNT                 : samples stored since reset, wraps at 2**32
module adc_sample_sink #(
  parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h4000_0000,
  parameter int unsigned                   C_WINDOW_BYTES     = 16,
  parameter int unsigned                   FIFO_AW            = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [FIFO_AW:0]                  FIFO_LEVEL,
  output logic [31:0]                       SAMPLE_CNT
);

  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] WIN_SIZE = C_S_AXI_ADDR_WIDTH'(C_WINDOW_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          aw_held_q, aw_held_d;
  logic                          w_held_q, w_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [FIFO_AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]              level_q, level_d;
  logic [31:0]                   sample_cnt_q, sample_cnt_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                          aw_hs, w_hs, b_hs;
  logic                          full, in_win, commit, push, pop;
  logic [C_S_AXI_DATA_WIDTH-1:0] push_data;

`ifdef ADC_SINK_ADDR_CHECK_EN
  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_off;
  // The window size is a power of two, so one unsigned compare of the wrapped
  // offset covers both bounds. Addresses below the base wrap to huge offsets.
  assign addr_off = awaddr_q - C_BASE_ADDR;
  assign in_win   = (addr_off < WIN_SIZE);
`else
  logic unused_addr;
  assign in_win      = 1'b1;
  assign unused_addr = ^{awaddr_q, C_BASE_ADDR, WIN_SIZE};
`endif

  always_comb begin
    aw_hs = awready_q && S_AXI_AWVALID;
    w_hs  = wready_q && S_AXI_WVALID;
    b_hs  = bvalid_q && S_AXI_BREADY;
    full  = (level_q == FULL_LEVEL);
    pop   = (level_q != '0) && M_AXIS_TREADY;
    // An out-of-window write never enters the FIFO, so it need not wait for space.
    commit = aw_held_q && w_held_q && !bvalid_q && (!full || !in_win);
    push   = commit && in_win;

    push_data = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (wstrb_q[i]) push_data[i*8 +: 8] = wdata_q[i*8 +: 8];
    end

    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    if (aw_hs)  aw_held_d = 1'b1;
    if (w_hs)   w_held_d  = 1'b1;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    awready_d = !aw_held_d;
    wready_d  = !w_held_d;

    awaddr_d = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wdata_d  = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d  = w_hs ? S_AXI_WSTRB : wstrb_q;

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (b_hs) bvalid_d = 1'b0;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = in_win ? RESP_OKAY : RESP_SLVERR;
    end

    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    sample_cnt_d = push ? sample_cnt_q + 32'd1 : sample_cnt_q;
    level_d      = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sample_cnt_q <= '0;
    end else begin
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Sample storage has no reset; entries become visible only through the pointers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign M_AXIS_TDATA  = mem_q[rd_ptr_q];
  assign M_AXIS_TVALID = (level_q != '0);
  assign FIFO_LEVEL    = level_q;
  assign SAMPLE_CNT    = sample_cnt_q;

endmodule

// File: doc/adc_sample_sink.md
Name: adc_sample_sink

Overview:
- AXI4-Lite write responder that terminates the ADC capture master's sample writes.
- Accepts single-beat writes on AW/W/B, applies byte strobes and queues each sample in a first-word-fall-through FIFO.
- Presents queued samples on an AXI4-Stream-style valid/ready output for downstream processing.
- Backpressure: a full FIFO stalls the write response, so no sample is ever lost.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, AXI address width.
- C_S_AXI_DATA_WIDTH, 32, AXI data width; also the stream TDATA width.
- C_BASE_ADDR, 32'h40000000, base of the accepted write window.
- C_WINDOW_BYTES, 16, window size in bytes (power of 2); used only with the optional feature.
- FIFO_AW, 4, FIFO address bits; depth = 2**FIFO_AW = 16.

Ports:
- S_AXI_ACLK  in  1  single clock, rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1  address valid.
- S_AXI_AWREADY  out  1  address ready.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data (ADC sample).
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID  in  1  data valid.
- S_AXI_WREADY  out  1  data ready.
- S_AXI_BRESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_BVALID  out  1  response valid.
- S_AXI_BREADY  in  1  response ready.
- M_AXIS_TDATA  out  C_S_AXI_DATA_WIDTH  head-of-FIFO sample.
- M_AXIS_TVALID  out  1  FIFO not empty.
- M_AXIS_TREADY  in  1  consumer ready.
- FIFO_LEVEL  out  FIFO_AW+1  current occupancy, 0..16.
- SAMPLE_CNT  out  32  samples stored since reset; wraps 32'hFFFFFFFF -> 0.

Behaviour:
- Reset (async, ARESETN low):
  - All outputs 0: AWREADY, WREADY, BVALID, BRESP, TVALID, FIFO_LEVEL, SAMPLE_CNT.
  - FIFO pointers, aw_held and w_held cleared.
  - A transaction in flight is discarded.
  - AWREADY and WREADY rise 1 cycle after deassertion.
- Write channels:
  - AWREADY = !aw_held; WREADY = !w_held, both registered.
  - AW handshake latches AWADDR and sets aw_held.
  - W handshake latches WDATA/WSTRB and sets w_held.
  - AW and W are accepted independently, in either order or in the same cycle.
- Commit:
  - Condition: aw_held && w_held && !BVALID && !full.
  - On the commit edge, push {WDATA with bytes whose WSTRB=0 forced to 8'h00}, increment SAMPLE_CNT, and clear aw_held/w_held.
  - BVALID=1 and BRESP=OKAY are set on the same edge.
- Latency: AW+W handshake in cycle N -> BVALID asserted in cycle N+2 when not full.
- Response channel: BVALID holds until BREADY; it clears on the handshake edge. Only one transaction is outstanding at a time.
- Full FIFO: commit stalls and BVALID stays low. Holds remain set, so AWREADY/WREADY stay low until a pop frees an entry. Commit occurs the edge after the pop.
- Same-cycle push and pop when full: the push is not allowed (full is evaluated pre-edge); the pop proceeds.
- Same-cycle push and pop when not full: FIFO_LEVEL is unchanged.
- FIFO: FWFT.
  - M_AXIS_TVALID = (level != 0).
  - M_AXIS_TDATA = mem[rd_ptr].
  - Pop on TVALID && TREADY.
  - Pointers are FIFO_AW bits and wrap modulo 16.
  - TDATA is stable while TVALID && !TREADY.
- Read channels are not implemented; the block is write-only.

Optional Feature:
- Macro: ADC_SINK_ADDR_CHECK_EN.
- Defined:
  - A write with AWADDR outside [C_BASE_ADDR, C_BASE_ADDR+C_WINDOW_BYTES) commits without push or count, ignoring the full condition.
  - It returns BRESP=2'b10 (SLVERR) with the same latency.
- Undefined: every address is accepted and BRESP is always OKAY.

Test Plan:
- AW 32'h40000000 and W 32'h00000ABC with WSTRB 4'hF in the same cycle, BREADY=1 -> BVALID in cycle N+2 with BRESP=00; TVALID=1, TDATA=32'h00000ABC; FIFO_LEVEL=1; SAMPLE_CNT=1.
- W 32'h12345678 with WSTRB 4'b0101 presented 3 cycles before AW -> stored sample 32'h00340078; AWREADY stays high until AW arrives.
- 16 writes with TREADY=0, then a 17th -> the 17th stalls with BVALID=0 and FIFO_LEVEL=16. Pulse TREADY for 1 cycle -> 17th commits the next edge; FIFO_LEVEL=16; popped TDATA = 1st sample.
- BREADY held 0 for 5 cycles after a commit -> BVALID stays 1 and AWREADY returns to 1. A second AW/W is accepted but not committed until the B handshake, then BVALID reasserts 1 cycle later.
- ARESETN pulled low asynchronously mid-stall with FIFO_LEVEL=8 -> all outputs 0 immediately; after release, TVALID=0 and SAMPLE_CNT=0.
- With ADC_SINK_ADDR_CHECK_EN: AW 32'h40000010 -> BRESP=10; FIFO_LEVEL and SAMPLE_CNT unchanged. AW 32'h4000000C -> OKAY and stored.
